uart_matmul_ctrl: RTL and testbench

- Command sequencer between the UART byte link (receiver/transmitter pair) and the systolic-array operand and result buffers.
- Parses framed host commands from received bytes and writes matrix A/B operands into the array buffers.
- Starts the array, waits for completion, then streams results back through the transmitter one byte at a time under the tx_done handshake.

---
 rtl/uart_matmul_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_matmul_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_matmul_ctrl.sv
// Command sequencer between a UART byte link and an N x N systolic array:
// parses framed host commands, loads operands, runs the array, streams results.
module uart_matmul_ctrl #(
  parameter int unsigned N       = 2,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_done,
  output logic [7:0]                tx_data,
  output logic                      tx_start,
  input  logic                      tx_done,
  output logic                      op_wr_en,
  output logic                      op_sel,
  output logic [$clog2(N*N)-1:0]    op_addr,
  output logic [7:0]                op_data,
  output logic                      arr_start,
  input  logic                      arr_done,
  output logic [$clog2(N*N)-1:0]    res_addr,
  input  logic [ACC_W-1:0]          res_data,
  output logic                      busy,
  output logic [7:0]                err_cnt
);

  localparam int unsigned NN     = N * N;
  localparam int unsigned ADDR_W = $clog2(NN);
  localparam int unsigned CNT_W  = $clog2(2 * NN + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_LOAD,
    S_CHK,
    S_START,
    S_WAIT,
    S_RESP_ACK,
    S_RESP_RD,
    S_RESP_HI,
    S_RESP_LO,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          xor_q, xor_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                results_valid_q, results_valid_d;
  logic                tx_sent_q, tx_sent_d;
  logic [15:0]         word_q, word_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                op_wr_en_q, op_wr_en_d;
  logic                op_sel_q, op_sel_d;
  logic [ADDR_W-1:0]   op_addr_q, op_addr_d;
  logic [7:0]          op_data_q, op_data_d;
  logic                arr_start_q, arr_start_d;
  logic [ADDR_W-1:0]   res_addr_q, res_addr_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic [15:0]         res_word;
  logic [7:0]          err_cnt_inc;
  logic                in_frame;
  logic                tmo_hit;
  logic                load_sel;

  assign res_word    = 16'(res_data);
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
  assign in_frame    = (state_q == S_CMD) || (state_q == S_LOAD) || (state_q == S_CHK);
  assign tmo_hit     = in_frame && !rx_done && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign load_sel    = (cnt_q >= CNT_W'(NN));

  always_comb begin
    state_d         = state_q;
    cmd_d           = cmd_q;
    xor_d           = xor_q;
    cnt_d           = cnt_q;
    tmo_d           = tmo_q;
    results_valid_d = results_valid_q;
    tx_sent_d       = tx_sent_q;
    word_d          = word_q;
    tx_data_d       = tx_data_q;
    tx_start_d      = 1'b0;
    op_wr_en_d      = 1'b0;
    op_sel_d        = op_sel_q;
    op_addr_d       = op_addr_q;
    op_data_d       = op_data_q;
    arr_start_d     = 1'b0;
    res_addr_d      = res_addr_q;
    err_cnt_d       = err_cnt_q;

    // Inter-byte watchdog: reloads on every byte while a frame is open.
    if (in_frame) begin
      if (rx_done) tmo_d = '0;
      else if (!tmo_hit) tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (rx_done && rx_data == 8'hA5) begin
          state_d = S_CMD;
          tmo_d   = '0;
        end
      end

      S_CMD: begin
        if (rx_done) begin
          cmd_d = rx_data;
          xor_d = rx_data;
          case (rx_data)
            8'h01: begin
              state_d         = S_LOAD;
              cnt_d           = '0;
              results_valid_d = 1'b0;
            end
            8'h02:   state_d = S_CHK;
            default: state_d = S_ERR;
          endcase
        end
      end

      S_LOAD: begin
        if (rx_done) begin
          op_wr_en_d = 1'b1;
          op_sel_d   = load_sel;
          op_addr_d  = load_sel ? ADDR_W'(cnt_q - CNT_W'(NN)) : ADDR_W'(cnt_q);
          op_data_d  = rx_data;
          xor_d      = xor_q ^ rx_data;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(2 * NN - 1)) state_d = S_CHK;
        end
      end

      S_CHK: begin
        if (rx_done) begin
          if (rx_data != xor_q)                        state_d = S_ERR;
          else if (cmd_q == 8'h01)                     state_d = S_START;
          else if (results_valid_q)                    state_d = S_RESP_ACK;
          else                                         state_d = S_ERR;
        end
      end

      S_START: begin
        arr_start_d = 1'b1;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        if (arr_done) begin
          results_valid_d = 1'b1;
          state_d         = S_RESP_ACK;
        end
      end

      S_RESP_ACK: begin
        if (!tx_sent_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = 8'h5A;
          tx_sent_d  = 1'b1;
        end else if (tx_done) begin
          tx_sent_d  = 1'b0;
          res_addr_d = '0;
          state_d    = S_RESP_RD;
        end
      end

      // res_addr is presented for one cycle before the synchronous read returns.
      S_RESP_RD: state_d = S_RESP_HI;

      S_RESP_HI: begin
        if (!tx_sent_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = res_word[15:8];
          word_d     = res_word;
          tx_sent_d  = 1'b1;
        end else if (tx_done) begin
          tx_sent_d = 1'b0;
          state_d   = S_RESP_LO;
        end
      end

      S_RESP_LO: begin
        if (!tx_sent_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = word_q[7:0];
          tx_sent_d  = 1'b1;
        end else if (tx_done) begin
          tx_sent_d = 1'b0;
          if (res_addr_q == ADDR_W'(NN - 1)) begin
            state_d = S_IDLE;
          end else begin
            res_addr_d = res_addr_q + ADDR_W'(1);
            state_d    = S_RESP_RD;
          end
        end
      end

      S_ERR: begin
        if (!tx_sent_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = 8'hEE;
          tx_sent_d  = 1'b1;
          err_cnt_d  = err_cnt_inc;
        end else if (tx_done) begin
          tx_sent_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (tmo_hit) begin
      state_d   = S_IDLE;
      err_cnt_d = err_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      cmd_q           <= '0;
      xor_q           <= '0;
      cnt_q           <= '0;
      tmo_q           <= '0;
      results_valid_q <= 1'b0;
      tx_sent_q       <= 1'b0;
      word_q          <= '0;
      tx_data_q       <= '0;
      tx_start_q      <= 1'b0;
      op_wr_en_q      <= 1'b0;
      op_sel_q        <= 1'b0;
      op_addr_q       <= '0;
      op_data_q       <= '0;
      arr_start_q     <= 1'b0;
      res_addr_q      <= '0;
      err_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      cmd_q           <= cmd_d;
      xor_q           <= xor_d;
      cnt_q           <= cnt_d;
      tmo_q           <= tmo_d;
      results_valid_q <= results_valid_d;
      tx_sent_q       <= tx_sent_d;
      word_q          <= word_d;
      tx_data_q       <= tx_data_d;
      tx_start_q      <= tx_start_d;
      op_wr_en_q      <= op_wr_en_d;
      op_sel_q        <= op_sel_d;
      op_addr_q       <= op_addr_d;
      op_data_q       <= op_data_d;
      arr_start_q     <= arr_start_d;
      res_addr_q      <= res_addr_d;
      err_cnt_q       <= err_cnt_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign op_wr_en  = op_wr_en_q;
  assign op_sel    = op_sel_q;
  assign op_addr   = op_addr_q;
  assign op_data   = op_data_q;
  assign arr_start = arr_start_q;
  assign res_addr  = res_addr_q;
  assign busy      = (state_q != S_IDLE);
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_matmul_ctrl.sv
// Scoreboard bench for uart_matmul_ctrl: models the UART TX, the operand
// buffers and a 2x2 array with synchronous result read.
module tb_uart_matmul_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        op_wr_en;
  logic        op_sel;
  logic [1:0]  op_addr;
  logic [7:0]  op_data;
  logic        arr_start;
  logic        arr_done;
  logic [1:0]  res_addr;
  logic [15:0] res_data;
  logic        busy;
  logic [7:0]  err_cnt;

  uart_matmul_ctrl #(.N(2), .ACC_W(16), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .op_wr_en(op_wr_en), .op_sel(op_sel), .op_addr(op_addr), .op_data(op_data),
    .arr_start(arr_start), .arr_done(arr_done), .res_addr(res_addr),
    .res_data(res_data), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  exp_tx[$];
  logic [10:0] exp_wr[$];

  logic [7:0]  buf_a[4];
  logic [7:0]  buf_b[4];
  logic [15:0] res_mem[4];
  int          arr_starts = 0;
  int          tx_cnt = 0;
  int          tx_delay = 3;
  logic        tx_outst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // UART transmitter model: checks each byte, answers with tx_done after tx_delay cycles.
  initial begin
    logic [7:0] hold;
    int cd;
    tx_done = 1'b0;
    hold = '0;
    cd = 0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!reset) begin
        tx_outst = 1'b0;
      end else if (tx_start) begin
        chk("tx_overlap", 32'(tx_outst), 32'd0);
        tx_cnt++;
        if (exp_tx.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'h100);
        else chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        hold = tx_data;
        tx_outst = 1'b1;
        cd = tx_delay;
      end else if (tx_outst) begin
        if (cd == 0) begin
          chk("tx_hold", 32'(tx_data), 32'(hold));
          tx_done = 1'b1;
          tx_outst = 1'b0;
        end else begin
          cd--;
        end
      end
    end
  end

  // Operand buffer write monitor.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (reset && op_wr_en) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 32'({op_sel, op_addr, op_data}), 32'h800);
        else begin
          e = exp_wr.pop_front();
          chk("op_wr", 32'({op_sel, op_addr, op_data}), 32'(e));
        end
        if (op_sel) buf_b[op_addr] = op_data;
        else        buf_a[op_addr] = op_data;
      end
    end
  end

  // Array model: multiplies the buffered operands, completes 5 cycles after start.
  initial begin
    int cd;
    arr_done = 1'b0;
    cd = 0;
    forever begin
      @(negedge clk);
      arr_done = 1'b0;
      if (!reset) cd = 0;
      else if (arr_start) begin
        arr_starts++;
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) begin
            res_mem[i*2+j] = '0;
            for (int k = 0; k < 2; k++)
              res_mem[i*2+j] = res_mem[i*2+j] + 16'(buf_a[i*2+k]) * 16'(buf_b[k*2+j]);
          end
        cd = 5;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) arr_done = 1'b1;
      end
    end
  end

  initial begin
    res_data = '0;
    forever begin
      @(posedge clk);
      res_data <= res_mem[res_addr];
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b; rx_done = 1'b1;
    @(posedge clk);
    #1 rx_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic push_resp();
    logic [15:0] c[4];
    c = '{16'd19, 16'd22, 16'd43, 16'd50};
    exp_tx.push_back(8'h5A);
    for (int i = 0; i < 4; i++) begin
      exp_tx.push_back(c[i][15:8]);
      exp_tx.push_back(c[i][7:0]);
    end
  endtask

  task automatic send_load(input logic [7:0] csum);
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 8; i++) begin
      exp_wr.push_back({(i >= 4) ? 1'b1 : 1'b0, 2'(i % 4), 8'(i + 1)});
      send_byte(8'(i + 1));
    end
    send_byte(csum);
  endtask

  task automatic send_read();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h02);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (n < max_cycles && (exp_tx.size() != 0 || busy || tx_outst)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= max_cycles), 32'd0);
    chk({tag, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
    chk({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    int starts0;
    int n;
    reset = 1'b0;
    rx_data = '0;
    rx_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      buf_a[i] = '0; buf_b[i] = '0; res_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_tx", {tx_start, tx_data}, 32'd0);
    chk("rst_op", {op_wr_en, op_sel, op_addr, op_data}, 32'd0);
    chk("rst_arr", {arr_start, res_addr}, 32'd0);
    chk("rst_stat", {busy, err_cnt}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Load and compute.
    push_resp();
    send_load(8'h09);
    wait_idle("load", 2000);
    chk("load_starts", arr_starts, 1);
    chk("load_err", err_cnt, 0);

    // Read back without recompute.
    push_resp();
    send_read();
    wait_idle("read", 2000);
    chk("read_starts", arr_starts, 1);

    // Read with no valid results after reset.
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    exp_tx.push_back(8'hEE);
    send_read();
    wait_idle("noval", 2000);
    chk("noval_err", err_cnt, 1);

    // Bad checksum: buffers written, array not started.
    starts0 = arr_starts;
    exp_tx.push_back(8'hEE);
    send_load(8'h0A);
    wait_idle("badck", 2000);
    chk("badck_starts", arr_starts, starts0);
    chk("badck_err", err_cnt, 2);
    exp_tx.push_back(8'hEE);
    send_read();
    wait_idle("badck_rd", 2000);
    chk("badck_rd_err", err_cnt, 3);

    // Mid-frame timeout.
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 3; i++) begin
      exp_wr.push_back({1'b0, 2'(i), 8'(i + 1)});
      send_byte(8'(i + 1));
    end
    repeat (85) @(negedge clk);
    chk("tmo_busy_hold", busy, 1);
    repeat (25) @(negedge clk);
    chk("tmo_busy_drop", busy, 0);
    chk("tmo_err", err_cnt, 4);
    chk("tmo_wr_left", exp_wr.size(), 0);
    push_resp();
    send_load(8'h09);
    wait_idle("after_tmo", 2000);
    chk("after_tmo_starts", arr_starts, starts0 + 1);

    // Slow transmitter with bytes injected during the response.
    tx_delay = 50;
    n = tx_cnt;
    push_resp();
    send_read();
    for (int c = 0; c < 500 && tx_cnt == n; c++) @(negedge clk);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h02);
    send_byte(8'hA5);
    wait_idle("slow", 3000);
    repeat (200) @(negedge clk);
    chk("slow_busy", busy, 0);
    chk("slow_tx_cnt", tx_cnt, n + 9);
    chk("slow_err", err_cnt, 4);

    // Reset in the middle of a response.
    n = tx_cnt;
    push_resp();
    send_read();
    for (int c = 0; c < 1000 && tx_cnt < n + 3; c++) @(negedge clk);
    chk("mid_reached", tx_cnt, n + 3);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_tx", {tx_start, tx_data}, 32'd0);
    chk("mid_op", {op_wr_en, op_sel, op_addr, op_data, arr_start, res_addr}, 32'd0);
    chk("mid_stat", {busy, err_cnt}, 32'd0);
    exp_tx.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (200) @(negedge clk);
    chk("mid_quiet", tx_cnt, n + 3);
    chk("mid_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
